datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  input  1  sole clock; all registers update on its rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 PCout, Zlowout, MDRout, R2out, R3out  input  1 each  bus-drive selects.
REQ-004 MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in  input  1 each  register load enables.
REQ-005 IncPC  input  1  ALU operation select: B+1.
REQ-006 OR  input  1  ALU operation select: Y OR B.
REQ-007 Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-008 Mdatain  input  32  memory data in.
REQ-009 BusMuxOut  output  32  current bus value; R1_q, PC_q, IR_q, MAR_q  output  32 each  register observation.
REQ-010 Positional port order SHALL be: PCout, Zlowout, MDRout, R2out, R3out, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, OR, R1in, R2in, R3in, Clock, Mdatain, Resetn, BusMuxOut, R1_q, PC_q, IR_q, MAR_q.

Function
REQ-011 Registers: PC, MAR, MDR, IR, Y, R1, R2, R3 (32 bits each), Z (64 bits, ZHi:ZLo).
REQ-012 Bus is combinational; selection priority when several selects are high: MDRout > Zlowout > PCout > R2out > R3out; no select high -> bus = 0.
REQ-013 Each register with its *in enable high SHALL load on the next rising edge: PC, MAR, IR, Y, R1, R2, R3 from the bus; Z from the ALU result.
REQ-014 MDR loads when MDRin = 1; its source is Mdatain when Read = 1, else the bus.
REQ-015 ALU inputs: A = Y, B = bus; result is 64 bits.
REQ-016 OR = 1 -> result = {32'h0, Y | B}; OR takes priority over IncPC.
REQ-017 IncPC = 1 (OR = 0) -> result = {32'h0, B + 1}, with mod 2^32 wrap (0xFFFFFFFF -> 0x00000000, ZHi = 0).
REQ-018 Neither OR nor IncPC -> result = {32'h0, B} (pass-through).
REQ-019 Zlowout drives Z[31:0]; ZHi is stored but not bus-visible in this block.
REQ-020 Register loads are simultaneous: a register read onto the bus and loaded in the same cycle captures the pre-edge value of its source, with no combinational loops.
REQ-021 Enables with no effect (e.g. R1in with an empty bus) load the bus value, which is 0.

Reset
REQ-022 Resetn = 0 SHALL immediately clear every register (PC, MAR, MDR, IR, Y, Z, R1-R3) to 0, independent of Clock.
REQ-023 Reset asserted mid-sequence discards any pending load; the first edge after release behaves normally.
REQ-024 Outputs are 0 while in reset, except BusMuxOut, which follows the selects over the cleared registers.

Structure
REQ-025 A shared package SHALL hold the width constant (WORD = 32) and the ALU result width (64).
REQ-026 One sub-module, register32 (32-bit, async active-low clear, load enable), SHALL be instantiated per register; Z uses two instances.
REQ-027 The bus mux and ALU are coded inline in datapath.

Verification
REQ-028 Register load: Mdatain = 0x12, Read = 1 and MDRin = 1 for one edge, then MDRout = 1 and R2in = 1 for one edge -> R2 = 0x00000012, BusMuxOut = 0x12 during the second cycle.
REQ-029 PC increment: from reset, PCout, IncPC and Zin for one edge -> Z = 1; then Zlowout and PCin for one edge -> PC_q = 0x00000001.
REQ-030 OR sequence: R2 = 0x12, R3 = 0x14; then R2out + Yin; then R3out + OR + Zin; then Zlowout + R1in -> R1_q = 0x00000016.
REQ-031 Instruction fetch: Mdatain = 0x28918000, Read + MDRin; then MDRout + IRin -> IR_q = 0x28918000.
REQ-032 Priority and wrap: PC = 0xFFFFFFFF, PCout + IncPC + OR + Zin with Y = 0 -> Z = 0xFFFFFFFF (OR wins); with OR = 0 -> Z = 0.
REQ-033 Async reset: drop Resetn between clock edges after R1 = 0x16 -> R1_q = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths and ALU operation encoding for the datapath slice.
package datapath_pkg;

  localparam int WORD   = 32;
  localparam int RESULT = 64;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_INC  = 2'd1,
    ALU_OR   = 2'd2
  } alu_op_t;

  // OR outranks IncPC when both selects are raised together.
  function automatic alu_op_t decode_alu(input logic or_sel, input logic inc_sel);
    if (or_sel)
      return ALU_OR;
    else if (inc_sel)
      return ALU_INC;
    else
      return ALU_PASS;
  endfunction

endpackage

// File: rtl/register32.sv
// Word-wide storage register with load enable and asynchronous active-low clear.
module register32
  import datapath_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [WORD-1:0] d,
  output logic [WORD-1:0] q
);

  // Capture d on a rising edge when load is high; clear at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/datapath.sv
// Single-bus processor datapath: register file, MDR, Y/Z around a small ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic            PCout,
  input  logic            Zlowout,
  input  logic            MDRout,
  input  logic            R2out,
  input  logic            R3out,
  input  logic            MARin,
  input  logic            Zin,
  input  logic            PCin,
  input  logic            MDRin,
  input  logic            IRin,
  input  logic            Yin,
  input  logic            IncPC,
  input  logic            Read,
  input  logic            OR,
  input  logic            R1in,
  input  logic            R2in,
  input  logic            R3in,
  input  logic            Clock,
  input  logic [WORD-1:0] Mdatain,
  input  logic            Resetn,
  output logic [WORD-1:0] BusMuxOut,
  output logic [WORD-1:0] R1_q,
  output logic [WORD-1:0] PC_q,
  output logic [WORD-1:0] IR_q,
  output logic [WORD-1:0] MAR_q
);

  logic [WORD-1:0]   bus;
  logic [WORD-1:0]   mdr;
  logic [WORD-1:0]   mdr_d;
  logic [WORD-1:0]   y;
  logic [WORD-1:0]   r2;
  logic [WORD-1:0]   r3;
  logic [WORD-1:0]   z_lo;
  logic [WORD-1:0]   unused_z_hi;
  logic [RESULT-1:0] alu_result;

  // Drive the shared bus from the highest-priority raised select, else zero.
  always_comb begin
    bus = '0;
    if (MDRout)
      bus = mdr;
    else if (Zlowout)
      bus = z_lo;
    else if (PCout)
      bus = PC_q;
    else if (R2out)
      bus = r2;
    else if (R3out)
      bus = r3;
  end

  // Compute the ALU result from Y and the bus; the upper word is always zero here.
  always_comb begin
    alu_result = '0;
    case (decode_alu(OR, IncPC))
      ALU_OR:  alu_result = {{(RESULT-WORD){1'b0}}, y | bus};
      ALU_INC: alu_result = {{(RESULT-WORD){1'b0}}, bus + 32'd1};
      default: alu_result = {{(RESULT-WORD){1'b0}}, bus};
    endcase
  end

  // Choose the MDR source: memory on a read, otherwise whatever is on the bus.
  always_comb begin
    mdr_d = Read ? Mdatain : bus;
  end

  assign BusMuxOut = bus;

  register32 u_pc  (.clk(Clock), .rst_n(Resetn), .load(PCin),  .d(bus),   .q(PC_q));
  register32 u_mar (.clk(Clock), .rst_n(Resetn), .load(MARin), .d(bus),   .q(MAR_q));
  register32 u_mdr (.clk(Clock), .rst_n(Resetn), .load(MDRin), .d(mdr_d), .q(mdr));
  register32 u_ir  (.clk(Clock), .rst_n(Resetn), .load(IRin),  .d(bus),   .q(IR_q));
  register32 u_y   (.clk(Clock), .rst_n(Resetn), .load(Yin),   .d(bus),   .q(y));
  register32 u_r1  (.clk(Clock), .rst_n(Resetn), .load(R1in),  .d(bus),   .q(R1_q));
  register32 u_r2  (.clk(Clock), .rst_n(Resetn), .load(R2in),  .d(bus),   .q(r2));
  register32 u_r3  (.clk(Clock), .rst_n(Resetn), .load(R3in),  .d(bus),   .q(r3));

  // Z is held as two word halves; the high half is kept for wider ALU ops but never reaches the bus.
  register32 u_z_lo (.clk(Clock), .rst_n(Resetn), .load(Zin), .d(alu_result[WORD-1:0]),      .q(z_lo));
  register32 u_z_hi (.clk(Clock), .rst_n(Resetn), .load(Zin), .d(alu_result[RESULT-1:WORD]), .q(unused_z_hi));

endmodule

// File: tb/tb_datapath.sv
// Directed scoreboard bench for the single-bus datapath.
module tb_datapath;

  logic        PCout, Zlowout, MDRout, R2out, R3out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        IncPC, Read, OR, R1in, R2in, R3in;
  logic        Clock;
  logic        Resetn;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, R1_q, PC_q, IR_q, MAR_q;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expectedQueue[$];

  localparam logic [31:0] VAL_A   = 32'h0000_0012;
  localparam logic [31:0] VAL_B   = 32'h0000_0014;
  localparam logic [31:0] INSTR   = 32'h2891_8000;
  localparam logic [31:0] ALLONES = 32'hFFFF_FFFF;
  localparam logic [31:0] LATE    = 32'h0000_005A;
  localparam logic [31:0] FRESH   = 32'h0000_0077;

  datapath dut (
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .OR(OR), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .Clock(Clock), .Mdatain(Mdatain), .Resetn(Resetn),
    .BusMuxOut(BusMuxOut), .R1_q(R1_q), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic clearControls();
    {PCout, Zlowout, MDRout, R2out, R3out} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin}   = '0;
    {IncPC, Read, OR, R1in, R2in, R3in}    = '0;
  endtask

  task automatic applyStimulus();
    @(posedge Clock);
    #1;
    clearControls();
  endtask

  task automatic pushExpected(input logic [31:0] value);
    expectedQueue.push_back(value);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    checks++;
    if (expectedQueue.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, observed);
    end else begin
      expected = expectedQueue.pop_front();
      assert (observed === expected) else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wrapped;
    clearControls();
    Mdatain = '0;
    Resetn  = 1'b0;

    #2;
    pushExpected(32'h0); checkOutput("reset_pc", PC_q);
    pushExpected(32'h0); checkOutput("reset_r1", R1_q);
    pushExpected(32'h0); checkOutput("reset_ir", IR_q);
    pushExpected(32'h0); checkOutput("reset_mar", MAR_q);
    pushExpected(32'h0); checkOutput("reset_bus", BusMuxOut);
    @(posedge Clock);
    #1;
    PCin = 1'b1;
    pushExpected(32'h0); checkOutput("reset_held_pc", PC_q);
    #2;
    Resetn = 1'b1;
    clearControls();

    PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    #1; pushExpected(32'h0); checkOutput("inc_bus_pc", BusMuxOut);
    applyStimulus();
    Zlowout = 1'b1; PCin = 1'b1;
    #1; pushExpected(32'h1); checkOutput("inc_bus_z", BusMuxOut);
    applyStimulus();
    pushExpected(32'h1); checkOutput("inc_pc", PC_q);

    Mdatain = VAL_A; Read = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1; R2in = 1'b1;
    #1; pushExpected(VAL_A); checkOutput("load_bus_mdr", BusMuxOut);
    applyStimulus();
    Mdatain = VAL_B; Read = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1; R3in = 1'b1;
    applyStimulus();

    R2out = 1'b1; Yin = 1'b1;
    #1; pushExpected(VAL_A); checkOutput("or_bus_r2", BusMuxOut);
    applyStimulus();
    R3out = 1'b1; OR = 1'b1; Zin = 1'b1;
    #1; pushExpected(VAL_B); checkOutput("or_bus_r3", BusMuxOut);
    applyStimulus();
    Zlowout = 1'b1; R1in = 1'b1;
    applyStimulus();
    pushExpected(VAL_A | VAL_B); checkOutput("or_r1", R1_q);

    R2out = 1'b1; MARin = 1'b1;
    applyStimulus();
    pushExpected(VAL_A); checkOutput("mar_load", MAR_q);

    Mdatain = INSTR; Read = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1; IRin = 1'b1;
    applyStimulus();
    pushExpected(INSTR); checkOutput("fetch_ir", IR_q);

    MDRout = 1'b1; Zlowout = 1'b1; PCout = 1'b1; R2out = 1'b1; R3out = 1'b1;
    #1; pushExpected(INSTR); checkOutput("prio_mdr", BusMuxOut);
    MDRout = 1'b0;
    #1; pushExpected(VAL_A | VAL_B); checkOutput("prio_z", BusMuxOut);
    Zlowout = 1'b0;
    #1; pushExpected(32'h1); checkOutput("prio_pc", BusMuxOut);
    PCout = 1'b0;
    #1; pushExpected(VAL_A); checkOutput("prio_r2", BusMuxOut);
    R2out = 1'b0;
    #1; pushExpected(VAL_B); checkOutput("prio_r3", BusMuxOut);
    clearControls();

    Mdatain = FRESH; Read = 1'b1; MDRin = 1'b1; MDRout = 1'b1; R2in = 1'b1;
    applyStimulus();
    R2out = 1'b1;
    #1; pushExpected(INSTR); checkOutput("simul_r2_old_mdr", BusMuxOut);
    clearControls(); MDRout = 1'b1;
    #1; pushExpected(FRESH); checkOutput("simul_mdr_new", BusMuxOut);
    clearControls();

    R3out = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1;
    #1; pushExpected(VAL_B); checkOutput("mdr_from_bus", BusMuxOut);
    clearControls();

    Mdatain = ALLONES; Read = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1; PCin = 1'b1;
    applyStimulus();
    pushExpected(ALLONES); checkOutput("wrap_pc_set", PC_q);
    Yin = 1'b1;
    applyStimulus();
    PCout = 1'b1; IncPC = 1'b1; OR = 1'b1; Zin = 1'b1;
    applyStimulus();
    Zlowout = 1'b1;
    #1; pushExpected(32'h0 | ALLONES); checkOutput("or_beats_inc", BusMuxOut);
    clearControls();
    PCout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    applyStimulus();
    Zlowout = 1'b1;
    wrapped = ALLONES + 32'd1;
    #1; pushExpected(wrapped); checkOutput("inc_wrap", BusMuxOut);
    clearControls();
    R3out = 1'b1; Zin = 1'b1;
    applyStimulus();
    Zlowout = 1'b1;
    #1; pushExpected(VAL_B); checkOutput("alu_pass", BusMuxOut);
    clearControls();

    Zlowout = 1'b1; PCin = 1'b1;
    #2;
    Resetn = 1'b0;
    #1;
    pushExpected(32'h0); checkOutput("async_r1", R1_q);
    pushExpected(32'h0); checkOutput("async_pc", PC_q);
    pushExpected(32'h0); checkOutput("async_ir", IR_q);
    pushExpected(32'h0); checkOutput("async_mar", MAR_q);
    pushExpected(32'h0); checkOutput("async_bus_z", BusMuxOut);
    #3;
    Resetn = 1'b1;
    applyStimulus();
    pushExpected(32'h0); checkOutput("post_reset_pc", PC_q);

    Mdatain = LATE; Read = 1'b1; MDRin = 1'b1;
    applyStimulus();
    MDRout = 1'b1; R1in = 1'b1;
    applyStimulus();
    pushExpected(LATE); checkOutput("post_reset_r1", R1_q);
    R1in = 1'b1;
    applyStimulus();
    pushExpected(32'h0); checkOutput("empty_bus_r1", R1_q);

    if (expectedQueue.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", expectedQueue.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
